// File: rtl/secded_pkg.sv
// SECDED sizing helpers, codeword position map and generic encoder.
// Supports payloads up to MAX_DW bits (codewords up to MAX_CW bits).
package secded_pkg;

  localparam int MAX_DW = 57;
  localparam int MAX_CW = 64;

  typedef logic [MAX_DW-1:0] dword_t;
  typedef logic [MAX_CW-1:0] cword_t;

  typedef enum logic [1:0] {
    DEC_CLEAN,
    DEC_SINGLE,
    DEC_DOUBLE
  } dec_kind_e;

  // Smallest Hamming parity count covering dw data bits.
  function automatic int calc_p(input int dw);
    int p;
    p = 7;
    for (int i = 7; i >= 1; i--)
      if ((1 << i) >= dw + i + 1) p = i;
    return p;
  endfunction

  function automatic int calc_cw(input int dw);
    return dw + calc_p(dw) + 1;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit idx.
  function automatic int data_pos(input int idx);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int pos = 1; pos < MAX_CW; pos++)
      if (!is_pow2(pos)) begin
        if (n == idx) r = pos;
        n++;
      end
    return r;
  endfunction

  // Bit 0 overall parity, powers of two Hamming parity.
  function automatic cword_t secded_encode(
    input int     dw,
    input dword_t d
  );
    cword_t cw;
    logic   x;
    int     p;
    cw = '0;
    p  = calc_p(dw);
    for (int i = 0; i < MAX_DW; i++)
      if (i < dw) cw[data_pos(i)] = d[i];
    for (int k = 0; k < 6; k++)
      if (k < p) begin
        x = 1'b0;
        for (int pos = 1; pos < MAX_CW; pos++)
          if (((pos >> k) & 1) == 1) x = x ^ cw[pos];
        cw[1 << k] = x;
      end
    cw[0] = ^cw[MAX_CW-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/secded_channel_decoder.sv
// Combinational SECDED decoder: syndrome, classify,
// correct one bit or pass raw data on uncorrectable errors.
module secded_decoder
  import secded_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int P    = calc_p(DATA_W),
  localparam int CW_W = calc_cw(DATA_W)
) (
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic              err_single,
  output logic              err_double
);

  logic [P-1:0]    syn;
  logic            pe;
  logic            syn_zero;
  logic            in_range;
  logic [CW_W-1:0] flip;
  logic [CW_W-1:0] fixed;
  dec_kind_e       kind;

  // Hamming syndrome over positions 1..CW_W-1.
  always_comb begin
    syn = '0;
    for (int pos = 1; pos < CW_W; pos++)
      for (int k = 0; k < P; k++)
        if (((pos >> k) & 1) == 1) syn[k] = syn[k] ^ cw[pos];
  end

  assign pe       = ^cw;
  assign syn_zero = (syn == '0);
  assign in_range = (int'(syn) <= CW_W - 1);

  // Classify the word and pick the bit to flip.
  always_comb begin
    flip = '0;
    kind = DEC_CLEAN;
    unique case (1'b1)
      syn_zero && !pe: kind = DEC_CLEAN;
      syn_zero && pe:  kind = DEC_SINGLE;
      !syn_zero && pe && in_range: begin
        kind = DEC_SINGLE;
        flip = CW_W'(1) << syn;
      end
      default: kind = DEC_DOUBLE;
    endcase
  end

  assign fixed      = cw ^ flip;
  assign err_single = (kind == DEC_SINGLE);
  assign err_double = (kind == DEC_DOUBLE);

  for (genvar i = 0; i < DATA_W; i++) begin : g_ext
    localparam int POS = data_pos(i);
    assign data[i] = fixed[POS];
  end

endmodule

// File: rtl/secded_channel.sv
// Two-stage SECDED channel: encode+inject, then decode+correct.
// SECDED_CNT_EN enables the saturating error counters and cnt_clr.
module secded_channel
  import secded_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  localparam int CW_W  = calc_cw(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CW_W-1:0]   inj_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_single,
  output logic              err_double,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  input  logic              cnt_clr
);

  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [CW_W-1:0]   enc;
  logic              s1_adv;
  logic              s2_adv;
  logic [DATA_W-1:0] dec_data;
  logic              dec_single;
  logic              dec_double;

  assign enc      = CW_W'(secded_encode(DATA_W, dword_t'(data_in)));
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // S1: capture the encoded, fault-injected codeword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_cw <= enc ^ inj_mask;
    end
  end

  secded_decoder #(
    .DATA_W(DATA_W)
  ) u_dec (
    .cw        (s1_cw),
    .data      (dec_data),
    .err_single(dec_single),
    .err_double(dec_double)
  );

  // S2: register decoded word and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= dec_data;
        err_single <= dec_single;
        err_double <= dec_double;
      end else begin
        err_single <= 1'b0;
        err_double <= 1'b0;
      end
    end
  end

`ifdef SECDED_CNT_EN
  logic fire;
  assign fire = out_valid && out_ready;

  // Saturating counters of delivered flagged words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (fire) begin
      if (err_single && corr_cnt != '1)
        corr_cnt <= corr_cnt + 1'b1;
      if (err_double && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`else
  logic cnt_unused;
  assign cnt_unused = cnt_clr;
  assign corr_cnt   = '0;
  assign uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_secded_channel.sv
// Randomised bench for secded_channel against a flip-count
// reference model (0 flips clean, 1 corrected, 2 uncorrectable).
module tb_secded_channel;

`ifdef SECDED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int DW   = 8;
  localparam int CWW  = 13;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  data_in;
  logic [CWW-1:0] inj_mask;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  data_out;
  logic           err_single;
  logic           err_double;
  logic [CW-1:0]  corr_cnt;
  logic [CW-1:0]  uncorr_cnt;
  logic           cnt_clr;

  secded_channel #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .inj_mask  (inj_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_single(err_single),
    .err_double(err_double),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt),
    .cnt_clr   (cnt_clr)
  );

  typedef struct {
    logic [DW-1:0]  d;
    logic [CWW-1:0] m;
  } tx_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          dbl;
  } exp_t;

  tx_t  txq[$];
  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   m_corr;
  int   m_uncorr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Data bits sit at the non-power-of-two positions, ascending.
  function automatic logic [DW-1:0] data_flips(input logic [CWW-1:0] m);
    logic [DW-1:0] r;
    int n;
    r = '0;
    n = 0;
    for (int pos = 1; pos < CWW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        r[n] = m[pos];
        n++;
      end
    return r;
  endfunction

  function automatic exp_t model(input logic [DW-1:0] d,
                                 input logic [CWW-1:0] m);
    exp_t e;
    int w;
    w = $countones(m);
    e.d   = (w == 2) ? (d ^ data_flips(m)) : d;
    e.s   = (w == 1);
    e.dbl = (w == 2);
    return e;
  endfunction

  function automatic logic [CWW-1:0] rand_mask();
    logic [CWW-1:0] m;
    int w;
    m = '0;
    w = $urandom_range(0, 2);
    while ($countones(m) < w) m[$urandom_range(0, CWW-1)] = 1'b1;
    return m;
  endfunction

  logic          pv, pr, have_prev;
  logic [DW-1:0] pd;
  logic          ps, pdb;

  // Monitor: scoreboard, hold-stability and counter model.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_corr   = 0;
      m_uncorr = 0;
      have_prev = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_data", data_out, 0);
      check("rst_flags", {err_single, err_double}, 0);
      check("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    end else begin
      check("corr_cnt", corr_cnt, m_corr);
      check("uncorr_cnt", uncorr_cnt, m_uncorr);
      if (have_prev && pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", data_out, pd);
        check("hold_flags", {err_single, err_double}, {ps, pdb});
      end
      if (out_valid)
        check("flag_excl", err_single & err_double, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e.d);
          check("err_single", err_single, e.s);
          check("err_double", err_double, e.dbl);
          if (CNT_EN && e.s && m_corr < CMAX) m_corr++;
          if (CNT_EN && e.dbl && m_uncorr < CMAX) m_uncorr++;
        end
      end
      if (cnt_clr) begin
        m_corr   = 0;
        m_uncorr = 0;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(data_in, inj_mask));
      pv = out_valid;
      pr = out_ready;
      pd = data_out;
      ps = err_single;
      pdb = err_double;
      have_prev = 1'b1;
    end
  end

  // Drive txq through the channel, then drain the pipeline.
  task automatic run(input int rmode, input int limit);
    int cyc;
    int acc_n;
    bit acc;
    cyc = 0;
    acc_n = 0;
    while ((txq.size() != 0 || exp_q.size() != 0) && cyc < limit) begin
      in_valid = (txq.size() != 0);
      if (in_valid) begin
        data_in  = txq[0].d;
        inj_mask = txq[0].m;
      end
      case (rmode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = (cyc >= 3);
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) acc_n++;
      if (rmode == 2 && cyc == 2) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_accepts", acc_n, 2);
      end
      @(posedge clk);
      #1;
      if (acc) void'(txq.pop_front());
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("drain", txq.size() + exp_q.size(), 0);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [CWW-1:0] m);
    tx_t t;
    t.d = d;
    t.m = m;
    txq.push_back(t);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_corr    = 0;
    m_uncorr  = 0;
    have_prev = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    inj_mask  = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Clean word, two-cycle latency.
    in_valid = 1'b1;
    data_in  = 8'hAA;
    inj_mask = '0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1", out_valid, 0);
    @(negedge clk);
    check("lat_edge2", out_valid, 1);
    check("t1_data", data_out, 8'hAA);
    check("t1_flags", {err_single, err_double}, 0);
    @(posedge clk);
    #1;

    push(8'hF0, 13'h0008);
    run(0, 50);
    check("t2_corr", corr_cnt, CNT_EN ? 1 : 0);

    push(8'h0F, 13'h000A);
    run(0, 50);
    check("t3_uncorr", uncorr_cnt, CNT_EN ? 1 : 0);
    check("t3_corr", corr_cnt, CNT_EN ? 1 : 0);

    push(8'h55, 13'h0001);
    run(0, 50);
    check("t4_corr", corr_cnt, CNT_EN ? 2 : 0);

    for (int i = 1; i <= 6; i++) push(DW'(i), '0);
    run(2, 100);

    for (int i = 0; i < 5; i++)
      push(DW'($urandom), CWW'(1) << $urandom_range(0, CWW-1));
    run(0, 100);
    check("t6_sat", corr_cnt, CNT_EN ? CMAX : 0);

    cnt_clr = 1'b1;
    push(8'h3C, 13'h0100);
    run(0, 50);
    cnt_clr = 1'b0;
    check("t6_clr", corr_cnt, 0);

    for (int i = 0; i < 300; i++) push(DW'($urandom), rand_mask());
    run(1, 3000);

    // Reset with words in flight.
    in_valid = 1'b1;
    data_in  = 8'h11;
    inj_mask = '0;
    @(posedge clk);
    #1;
    data_in = 8'h22;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'h99, 13'h0040);
    run(0, 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
